md5_batch_feeder: RTL and testbench

Upstream stage of `string_process_match`. Accepts a batch command and a 32-bit word stream from the PS-side DMA, then issues `proc_start` and serializes the words into one byte per cycle on `proc_data`. It waits for `proc_done`, reads out the matched string through `proc_match_char_next`, and presents one result record back to the PS.

---
 rtl/md5_batch_feeder.sv | 212 +++++++++++++++++++++
 tb/tb_md5_batch_feeder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_batch_feeder.sv
// Batch front end for string_process_match: latches the batch command, serializes the
// 32-bit word stream one byte per cycle, then collects the matched string into one result record.
module md5_batch_feeder #(
  parameter int unsigned MAX_CHARS = 55
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_start,
  input  logic [31:0]            cfg_num_bytes,
  input  logic [15:0]            cfg_str_len,
  input  logic [31:0]            s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   proc_start,
  output logic [31:0]            proc_num_bytes,
  output logic [15:0]            proc_str_len,
  output logic [7:0]             proc_data,
  output logic                   proc_data_valid,
  input  logic                   proc_done,
  input  logic                   proc_match,
  input  logic [31:0]            proc_byte_pos,
  input  logic [7:0]             proc_match_char,
  output logic                   proc_match_char_next,
  output logic                   busy,
  output logic                   res_valid,
  output logic                   res_match,
  output logic [31:0]            res_byte_pos,
  output logic [8*MAX_CHARS-1:0] res_str
);

  localparam int unsigned STR_W = 8 * MAX_CHARS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FEED,
    S_GUARD,
    S_DRAIN,
    S_READ,
    S_REPORT
  } state_t;

  state_t state_q, state_d;

  // buf_q holds the bytes of the current word not yet moved onto proc_data
  logic [23:0]      buf_q, buf_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d;
  logic [5:0]       chars_q, chars_d;

  logic             s_ready_q, s_ready_d;
  logic             proc_start_q, proc_start_d;
  logic [31:0]      proc_num_bytes_q, proc_num_bytes_d;
  logic [15:0]      proc_str_len_q, proc_str_len_d;
  logic [7:0]       proc_data_q, proc_data_d;
  logic             proc_data_valid_q, proc_data_valid_d;
  logic             proc_match_char_next_q, proc_match_char_next_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic             res_match_q, res_match_d;
  logic [31:0]      res_byte_pos_q, res_byte_pos_d;
  logic [STR_W-1:0] res_str_q, res_str_d;

  logic [15:0]      n_cfg;
  logic [15:0]      n_total;
  logic [15:0]      shamt;
  logic [STR_W-1:0] shifted;

  // Character counts (clamped to MAX_CHARS) and the left-align amount for the result
  always_comb begin
    n_cfg = cfg_str_len >> 3;
    if (n_cfg > 16'(MAX_CHARS)) n_cfg = 16'(MAX_CHARS);
    n_total = proc_str_len_q >> 3;
    if (n_total > 16'(MAX_CHARS)) n_total = 16'(MAX_CHARS);
    shamt   = (16'(MAX_CHARS) - n_total) << 3;
    shifted = {res_str_q[STR_W-9:0], proc_match_char};
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d                = state_q;
    buf_d                  = buf_q;
    cnt_d                  = cnt_q;
    rem_d                  = rem_q;
    chars_d                = chars_q;
    proc_num_bytes_d       = proc_num_bytes_q;
    proc_str_len_d         = proc_str_len_q;
    proc_data_d            = proc_data_q;
    proc_data_valid_d      = 1'b0;
    res_match_d            = res_match_q;
    res_byte_pos_d         = res_byte_pos_q;
    res_str_d              = res_str_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          proc_num_bytes_d = cfg_num_bytes;
          proc_str_len_d   = cfg_str_len;
          rem_d            = cfg_num_bytes;
          chars_d          = 6'(n_cfg);
          res_str_d        = '0;
          state_d          = S_START;
        end
      end
      S_START: begin
        state_d = (rem_q == 32'd0) ? S_GUARD : S_FEED;
      end
      S_FEED: begin
        if (cnt_q != 2'd0) begin
          proc_data_d       = buf_q[7:0];
          proc_data_valid_d = 1'b1;
          buf_d             = {8'h00, buf_q[23:8]};
          cnt_d             = cnt_q - 2'd1;
          rem_d             = rem_q - 32'd1;
        end else if (s_valid && s_ready_q) begin
          // Byte 0 goes straight out; bytes past the batch end are never counted
          proc_data_d       = s_data[7:0];
          proc_data_valid_d = 1'b1;
          buf_d             = s_data[31:8];
          cnt_d             = (rem_q > 32'd3) ? 2'd3 : 2'(rem_q - 32'd1);
          rem_d             = rem_q - 32'd1;
        end else if (rem_q == 32'd0) begin
          state_d = S_GUARD;
        end
      end
      S_GUARD: begin
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (proc_done) begin
          res_match_d    = proc_match;
          res_byte_pos_d = proc_byte_pos;
          state_d        = (proc_match && chars_q != 6'd0) ? S_READ : S_REPORT;
        end
      end
      S_READ: begin
        res_str_d = shifted;
        chars_d   = chars_q - 6'd1;
        if (chars_q <= 6'd1) begin
          res_str_d = shifted << shamt;
          state_d   = S_REPORT;
        end
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    s_ready_d              = (state_d == S_FEED) && (cnt_d == 2'd0) && (rem_d != 32'd0);
    proc_start_d           = (state_d == S_START);
    proc_match_char_next_d = (state_d == S_READ);
    res_valid_d            = (state_d == S_REPORT);
    busy_d                 = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q                <= S_IDLE;
      buf_q                  <= '0;
      cnt_q                  <= '0;
      rem_q                  <= '0;
      chars_q                <= '0;
      s_ready_q              <= 1'b0;
      proc_start_q           <= 1'b0;
      proc_num_bytes_q       <= '0;
      proc_str_len_q         <= '0;
      proc_data_q            <= '0;
      proc_data_valid_q      <= 1'b0;
      proc_match_char_next_q <= 1'b0;
      busy_q                 <= 1'b0;
      res_valid_q            <= 1'b0;
      res_match_q            <= 1'b0;
      res_byte_pos_q         <= '0;
      res_str_q              <= '0;
    end else begin
      state_q                <= state_d;
      buf_q                  <= buf_d;
      cnt_q                  <= cnt_d;
      rem_q                  <= rem_d;
      chars_q                <= chars_d;
      s_ready_q              <= s_ready_d;
      proc_start_q           <= proc_start_d;
      proc_num_bytes_q       <= proc_num_bytes_d;
      proc_str_len_q         <= proc_str_len_d;
      proc_data_q            <= proc_data_d;
      proc_data_valid_q      <= proc_data_valid_d;
      proc_match_char_next_q <= proc_match_char_next_d;
      busy_q                 <= busy_d;
      res_valid_q            <= res_valid_d;
      res_match_q            <= res_match_d;
      res_byte_pos_q         <= res_byte_pos_d;
      res_str_q              <= res_str_d;
    end
  end

  assign s_ready              = s_ready_q;
  assign proc_start           = proc_start_q;
  assign proc_num_bytes       = proc_num_bytes_q;
  assign proc_str_len         = proc_str_len_q;
  assign proc_data            = proc_data_q;
  assign proc_data_valid      = proc_data_valid_q;
  assign proc_match_char_next = proc_match_char_next_q;
  assign busy                 = busy_q;
  assign res_valid            = res_valid_q;
  assign res_match            = res_match_q;
  assign res_byte_pos         = res_byte_pos_q;
  assign res_str              = res_str_q;

endmodule

// File: tb/tb_md5_batch_feeder.sv
// Directed bench for md5_batch_feeder: stream source and string-processor model driven per
// cycle at the falling edge, outputs sampled there, cycle 0 = the cfg_start cycle.
module tb_md5_batch_feeder;

  localparam int unsigned MAX_CHARS = 55;
  localparam int unsigned STR_W     = 8 * MAX_CHARS;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_start;
  logic [31:0]      cfg_num_bytes;
  logic [15:0]      cfg_str_len;
  logic [31:0]      s_data;
  logic             s_valid;
  logic             s_ready;
  logic             proc_start;
  logic [31:0]      proc_num_bytes;
  logic [15:0]      proc_str_len;
  logic [7:0]       proc_data;
  logic             proc_data_valid;
  logic             proc_done;
  logic             proc_match;
  logic [31:0]      proc_byte_pos;
  logic [7:0]       proc_match_char;
  logic             proc_match_char_next;
  logic             busy;
  logic             res_valid;
  logic             res_match;
  logic [31:0]      res_byte_pos;
  logic [STR_W-1:0] res_str;

  md5_batch_feeder #(.MAX_CHARS(MAX_CHARS)) dut (
    .clk                 (clk),
    .reset               (reset),
    .cfg_start           (cfg_start),
    .cfg_num_bytes       (cfg_num_bytes),
    .cfg_str_len         (cfg_str_len),
    .s_data              (s_data),
    .s_valid             (s_valid),
    .s_ready             (s_ready),
    .proc_start          (proc_start),
    .proc_num_bytes      (proc_num_bytes),
    .proc_str_len        (proc_str_len),
    .proc_data           (proc_data),
    .proc_data_valid     (proc_data_valid),
    .proc_done           (proc_done),
    .proc_match          (proc_match),
    .proc_byte_pos       (proc_byte_pos),
    .proc_match_char     (proc_match_char),
    .proc_match_char_next(proc_match_char_next),
    .busy                (busy),
    .res_valid           (res_valid),
    .res_match           (res_match),
    .res_byte_pos        (res_byte_pos),
    .res_str             (res_str)
  );

  always #5 clk = ~clk;

  wire any_out = busy | s_ready | proc_start | proc_data_valid | proc_match_char_next |
                 res_valid | res_match | (|proc_num_bytes) | (|proc_str_len) |
                 (|proc_data) | (|res_byte_pos) | (|res_str);

  int total = 0;
  int bad   = 0;

  logic [31:0] words [0:3];
  logic [7:0]  mstr  [0:3];
  logic [7:0]  got   [$];

  int ps_cnt, ps_cyc, first_rdy, first_byte, last_byte, acc_cnt, rdy_extra;
  int nxt_cnt, first_next, last_next, rv_cnt, rv_cyc, cfg_bad;
  bit timed_out;
  logic             cap_match;
  logic [31:0]      cap_pos;
  logic [STR_W-1:0] cap_str;

  // One batch: cycle 0 pulses cfg_start, a second ignored pulse lands in cycle 4
  task automatic run_batch(input int nbytes, input int slen, input int vmode, input int done_at,
                           input bit mt, input logic [31:0] pos, input bit stale,
                           input int abort_bytes);
    int  widx;
    int  cidx;
    bit  stop;
    got.delete();
    ps_cnt = 0; ps_cyc = -1; first_rdy = -1; first_byte = -1; last_byte = -1;
    acc_cnt = 0; rdy_extra = 0; nxt_cnt = 0; first_next = -1; last_next = -1;
    rv_cnt = 0; rv_cyc = -1; cfg_bad = 0; timed_out = 1'b1;
    widx = 0; cidx = 0; stop = 1'b0;
    for (int k = 0; k < 300 && !stop; k++) begin
      @(negedge clk);
      if (proc_start) begin ps_cnt++; ps_cyc = k; end
      if (s_ready && first_rdy < 0) first_rdy = k;
      if (s_ready && acc_cnt >= (nbytes + 3) / 4) rdy_extra++;
      if (proc_data_valid) begin
        got.push_back(proc_data);
        if (first_byte < 0) first_byte = k;
        last_byte = k;
      end
      if (proc_match_char_next) begin
        nxt_cnt++;
        if (first_next < 0) first_next = k;
        last_next = k;
      end
      if (res_valid) begin
        rv_cnt++; rv_cyc = k;
        cap_match = res_match; cap_pos = res_byte_pos; cap_str = res_str;
      end
      if (k >= 1 && (proc_num_bytes !== 32'(nbytes) || proc_str_len !== 16'(slen))) cfg_bad++;

      cfg_start     = (k == 0) || (k == 4);
      cfg_num_bytes = (k == 0) ? 32'(nbytes) : 32'hFFFF_FFF0;
      cfg_str_len   = (k == 0) ? 16'(slen) : 16'd200;
      s_valid       = (vmode == 0) ? 1'b1 : (((k / 3) % 2) == 0);
      s_data        = (widx < 4) ? words[widx] : 32'hDEAD_BEEF;
      if (s_valid && s_ready) begin acc_cnt++; widx++; end
      if (stale && k <= 2) begin
        proc_done = 1'b1; proc_match = 1'b1; proc_byte_pos = 32'hAAAA_AAAA;
      end else if (k >= done_at && rv_cnt == 0) begin
        proc_done = 1'b1; proc_match = mt; proc_byte_pos = pos;
      end else begin
        proc_done = 1'b0; proc_match = 1'b0; proc_byte_pos = 32'h0;
      end
      proc_match_char = (cidx < 4) ? mstr[cidx] : 8'h00;
      if (proc_match_char_next) cidx++;
      if (rv_cnt > 0 && k >= rv_cyc + 2) begin timed_out = 1'b0; stop = 1'b1; end
      if (abort_bytes > 0 && got.size() == abort_bytes) begin
        reset = 1'b1; cfg_start = 1'b0; timed_out = 1'b0; stop = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_start = 1'b0; cfg_num_bytes = 32'h0; cfg_str_len = 16'h0;
    s_data = 32'h0; s_valid = 1'b0; proc_done = 1'b0; proc_match = 1'b0;
    proc_byte_pos = 32'h0; proc_match_char = 8'h0;
    repeat (3) @(negedge clk);
    total++;
    if (any_out !== 1'b0) begin bad++; $display("FAIL reset_outputs got=%b exp=0", any_out); end
    total++;
    if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    reset = 1'b0;
  endtask

  task automatic test_len8();
    run_batch(8, 8, 0, 14, 1'b0, 32'h0, 1'b0, 0);
    total++; if (timed_out) begin bad++; $display("FAIL len8_timeout got=1 exp=0"); end
    total++; if (ps_cnt != 1 || ps_cyc != 1) begin bad++; $display("FAIL len8_proc_start cnt=%0d cyc=%0d exp=1/1", ps_cnt, ps_cyc); end
    total++; if (first_rdy != 2) begin bad++; $display("FAIL len8_s_ready_cycle got=%0d exp=2", first_rdy); end
    total++; if (first_byte != 3 || last_byte != 10) begin bad++; $display("FAIL len8_byte_window got=%0d..%0d exp=3..10", first_byte, last_byte); end
    total++; if (got.size() != 8) begin bad++; $display("FAIL len8_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (got.size() <= i) begin bad++; $display("FAIL len8_byte%0d got=none exp=%h", i, 8'(8'h61 + i)); end
      else if (got[i] !== 8'(8'h61 + i)) begin bad++; $display("FAIL len8_byte%0d got=%h exp=%h", i, got[i], 8'(8'h61 + i)); end
    end
    total++; if (acc_cnt != 2 || rdy_extra != 0) begin bad++; $display("FAIL len8_words acc=%0d extra_ready=%0d exp=2/0", acc_cnt, rdy_extra); end
    total++; if (cfg_bad != 0) begin bad++; $display("FAIL len8_cfg_latch bad_cycles=%0d exp=0", cfg_bad); end
    total++; if (rv_cnt != 1 || rv_cyc != 15 || cap_match !== 1'b0) begin bad++; $display("FAIL len8_result cnt=%0d cyc=%0d match=%b exp=1/15/0", rv_cnt, rv_cyc, cap_match); end
  endtask

  task automatic test_partial();
    run_batch(6, 8, 0, 12, 1'b0, 32'h0, 1'b0, 0);
    total++; if (timed_out) begin bad++; $display("FAIL partial_timeout got=1 exp=0"); end
    total++; if (got.size() != 6) begin bad++; $display("FAIL partial_count got=%0d exp=6", got.size()); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (got.size() <= i) begin bad++; $display("FAIL partial_byte%0d got=none exp=%h", i, 8'(8'h61 + i)); end
      else if (got[i] !== 8'(8'h61 + i)) begin bad++; $display("FAIL partial_byte%0d got=%h exp=%h", i, got[i], 8'(8'h61 + i)); end
    end
    total++; if (first_byte != 3 || last_byte != 8) begin bad++; $display("FAIL partial_byte_window got=%0d..%0d exp=3..8", first_byte, last_byte); end
    total++; if (acc_cnt != 2 || rdy_extra != 0) begin bad++; $display("FAIL partial_words acc=%0d extra_ready=%0d exp=2/0", acc_cnt, rdy_extra); end
    total++; if (rv_cnt != 1 || rv_cyc != 13) begin bad++; $display("FAIL partial_result cnt=%0d cyc=%0d exp=1/13", rv_cnt, rv_cyc); end
  endtask

  task automatic test_backpressure();
    run_batch(12, 8, 1, 25, 1'b0, 32'h0, 1'b0, 0);
    total++; if (timed_out) begin bad++; $display("FAIL bp_timeout got=1 exp=0"); end
    total++; if (got.size() != 12) begin bad++; $display("FAIL bp_count got=%0d exp=12", got.size()); end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (got.size() <= i) begin bad++; $display("FAIL bp_byte%0d got=none exp=%h", i, 8'(8'h61 + i)); end
      else if (got[i] !== 8'(8'h61 + i)) begin bad++; $display("FAIL bp_byte%0d got=%h exp=%h", i, got[i], 8'(8'h61 + i)); end
    end
    total++; if (first_byte != 3 || last_byte != 16) begin bad++; $display("FAIL bp_byte_window got=%0d..%0d exp=3..16", first_byte, last_byte); end
    total++; if (acc_cnt != 3 || rdy_extra != 0) begin bad++; $display("FAIL bp_words acc=%0d extra_ready=%0d exp=3/0", acc_cnt, rdy_extra); end
    total++; if (rv_cnt != 1 || rv_cyc != 26) begin bad++; $display("FAIL bp_result cnt=%0d cyc=%0d exp=1/26", rv_cnt, rv_cyc); end
  endtask

  task automatic test_match();
    logic [STR_W-1:0] exp_str;
    exp_str = '0;
    exp_str[STR_W-1 -: 24] = 24'h636174;
    run_batch(4, 24, 0, 10, 1'b1, 32'h0000_001F, 1'b0, 0);
    total++; if (timed_out) begin bad++; $display("FAIL match_timeout got=1 exp=0"); end
    total++; if (got.size() != 4) begin bad++; $display("FAIL match_count got=%0d exp=4", got.size()); end
    total++; if (nxt_cnt != 3 || first_next != 11 || last_next != 13) begin bad++; $display("FAIL match_next cnt=%0d cyc=%0d..%0d exp=3/11..13", nxt_cnt, first_next, last_next); end
    total++; if (rv_cnt != 1 || rv_cyc != 14) begin bad++; $display("FAIL match_res_valid cnt=%0d cyc=%0d exp=1/14", rv_cnt, rv_cyc); end
    total++; if (cap_match !== 1'b1 || cap_pos !== 32'h1F) begin bad++; $display("FAIL match_fields match=%b pos=%h exp=1/0000001f", cap_match, cap_pos); end
    total++; if (cap_str !== exp_str) begin bad++; $display("FAIL match_str got_top=%h exp_top=636174 low_nonzero=%b", cap_str[STR_W-1 -: 32], |cap_str[STR_W-25:0]); end
  endtask

  task automatic test_stale_done();
    run_batch(0, 8, 0, 6, 1'b0, 32'h0000_0077, 1'b1, 0);
    total++; if (timed_out) begin bad++; $display("FAIL stale_timeout got=1 exp=0"); end
    total++; if (ps_cnt != 1 || ps_cyc != 1) begin bad++; $display("FAIL stale_proc_start cnt=%0d cyc=%0d exp=1/1", ps_cnt, ps_cyc); end
    total++; if (got.size() != 0 || first_rdy != -1 || acc_cnt != 0) begin bad++; $display("FAIL stale_no_stream bytes=%0d ready_cyc=%0d acc=%0d exp=0/-1/0", got.size(), first_rdy, acc_cnt); end
    total++; if (rv_cnt != 1 || rv_cyc != 7) begin bad++; $display("FAIL stale_res_valid cnt=%0d cyc=%0d exp=1/7", rv_cnt, rv_cyc); end
    total++; if (cap_match !== 1'b0 || cap_pos !== 32'h77) begin bad++; $display("FAIL stale_fields match=%b pos=%h exp=0/00000077", cap_match, cap_pos); end
    total++; if (nxt_cnt != 0) begin bad++; $display("FAIL stale_next got=%0d exp=0", nxt_cnt); end
    total++; if (cap_str !== '0) begin bad++; $display("FAIL stale_str_cleared got_top=%h exp=0", cap_str[STR_W-1 -: 32]); end
  endtask

  task automatic test_mid_reset();
    run_batch(8, 8, 0, 14, 1'b0, 32'h0, 1'b0, 3);
    total++; if (timed_out || got.size() != 3) begin bad++; $display("FAIL midrst_prefix bytes=%0d timeout=%b exp=3/0", got.size(), timed_out); end
    @(negedge clk);
    total++; if (any_out !== 1'b0) begin bad++; $display("FAIL midrst_outputs got=%b exp=0", any_out); end
    reset = 1'b0;
    run_batch(8, 8, 0, 14, 1'b0, 32'h0, 1'b0, 0);
    total++; if (timed_out) begin bad++; $display("FAIL midrst_timeout got=1 exp=0"); end
    total++; if (ps_cnt != 1 || first_byte != 3 || got.size() != 8) begin bad++; $display("FAIL midrst_rerun start=%0d first=%0d bytes=%0d exp=1/3/8", ps_cnt, first_byte, got.size()); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (got.size() <= i) begin bad++; $display("FAIL midrst_byte%0d got=none exp=%h", i, 8'(8'h61 + i)); end
      else if (got[i] !== 8'(8'h61 + i)) begin bad++; $display("FAIL midrst_byte%0d got=%h exp=%h", i, got[i], 8'(8'h61 + i)); end
    end
    total++; if (rv_cnt != 1 || rv_cyc != 15) begin bad++; $display("FAIL midrst_result cnt=%0d cyc=%0d exp=1/15", rv_cnt, rv_cyc); end
  endtask

  initial begin
    words[0] = 32'h6463_6261;
    words[1] = 32'h6867_6665;
    words[2] = 32'h6C6B_6A69;
    words[3] = 32'h706F_6E6D;
    mstr[0]  = 8'h63;
    mstr[1]  = 8'h61;
    mstr[2]  = 8'h74;
    mstr[3]  = 8'h21;
    test_reset();
    test_len8();
    test_partial();
    test_backpressure();
    test_match();
    test_stale_done();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
